// File: rtl/encoder_axil_pkg.sv
// Shared register map, response codes and CTRL bit positions for the
// quadrature encoder AXI4-Lite slave.
package encoder_axil_pkg;

  typedef logic [2:0] reg_idx_t;

  // Register indices are the byte offset divided by four (address bits [4:2]).
  localparam reg_idx_t REG_CTRL     = 3'd0;
  localparam reg_idx_t REG_SCRATCH1 = 3'd1;
  localparam reg_idx_t REG_SCRATCH2 = 3'd2;
  localparam reg_idx_t REG_SCRATCH3 = 3'd3;
  localparam reg_idx_t REG_POSITION = 3'd4;
  localparam reg_idx_t REG_ERRCNT   = 3'd5;

  localparam int NUM_RW_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  function automatic logic is_mapped(input reg_idx_t idx);
    return idx <= REG_ERRCNT;
  endfunction

  function automatic logic is_writable(input reg_idx_t idx);
    return idx <= REG_SCRATCH3;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature input synchroniser, x4 decoder, position counter and
// saturating illegal-transition counter.
module quad_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        enable,
  input  logic        clear,
  output logic [31:0] position,
  output logic [31:0] errcnt
);

  logic [1:0]  sync1_reg, sync2_reg, prev_reg;
  logic [31:0] pos_reg, pos_next;
  logic [31:0] err_reg, err_next;
  logic [1:0]  step;

  // Gray phase to binary so a single step is +1 or -1 modulo 4.
  function automatic logic [1:0] gray_to_bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign step = gray_to_bin(sync2_reg) - gray_to_bin(prev_reg);

  always_comb begin
    pos_next = pos_reg;
    err_next = err_reg;
    if (clear) begin
      pos_next = '0;
      err_next = '0;
    end else if (enable) begin
      case (step)
        2'd1: pos_next = pos_reg + 32'd1;
        2'd3: pos_next = pos_reg - 32'd1;
        2'd2: if (err_reg != 32'hFFFF_FFFF) err_next = err_reg + 32'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      pos_reg   <= '0;
      err_reg   <= '0;
    end else begin
      sync1_reg <= {a, b};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      pos_reg   <= pos_next;
      err_reg   <= err_next;
    end
  end

  assign position = pos_reg;
  assign errcnt   = err_reg;

endmodule

// File: rtl/encoder_axil_slave.sv
// AXI4-Lite register slave wrapping a quadrature decoder: CTRL, three
// scratch registers and read-only POSITION / ERRCNT.
module encoder_axil_slave
  import encoder_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            enc_a,
  input  logic                            enc_b
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  logic          ready_en_reg;
  logic          aw_done_reg, w_done_reg;
  reg_idx_t      aw_idx_reg;
  logic [DW-1:0] w_data_reg;
  logic [SW-1:0] w_strb_reg;
  logic          bvalid_reg, rvalid_reg;
  logic [1:0]    bresp_reg, rresp_reg, rd_resp_next;
  logic [DW-1:0] rdata_reg, rd_data_next;
  logic          commit;
  reg_idx_t      rd_idx;
  logic [DW-1:0] position, errcnt;
  logic [NUM_RW_REGS-1:0][DW-1:0] reg_words;
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies stay low until the first edge after reset has been released.
  assign S_AXI_AWREADY = ready_en_reg & ~aw_done_reg & ~bvalid_reg;
  assign S_AXI_WREADY  = ready_en_reg & ~w_done_reg & ~bvalid_reg;
  assign S_AXI_ARREADY = ready_en_reg & ~rvalid_reg;
  assign commit        = aw_done_reg & w_done_reg;
  assign rd_idx        = S_AXI_ARADDR[4:2];

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      ready_en_reg <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      ready_en_reg <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_done_reg <= 1'b1;
        aw_idx_reg  <= S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_done_reg <= 1'b1;
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= is_mapped(aw_idx_reg) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_reg && S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RW_REGS; gi++) begin : g_rw
      logic [DW-1:0] word_reg;
      always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
          word_reg <= '0;
        end else if (commit && aw_idx_reg == 3'(gi)) begin
          for (int bi = 0; bi < SW; bi++) begin
            if (w_strb_reg[bi]) word_reg[8*bi +: 8] <= w_data_reg[8*bi +: 8];
          end
        end
      end
      assign reg_words[gi] = word_reg;
    end
  endgenerate

  // Reads see register state before any write committing in the same cycle.
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_OKAY;
    if (!is_mapped(rd_idx))          rd_resp_next = RESP_SLVERR;
    else if (is_writable(rd_idx))    rd_data_next = reg_words[rd_idx[1:0]];
    else if (rd_idx == REG_POSITION) rd_data_next = position;
    else                             rd_data_next = errcnt;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_data_next;
      rresp_reg  <= rd_resp_next;
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_reg;
  assign S_AXI_BRESP  = bresp_reg;
  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign S_AXI_RRESP  = rresp_reg;

  quad_decoder u_quad (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .a        (enc_a),
    .b        (enc_b),
    .enable   (reg_words[REG_CTRL][CTRL_EN_BIT]),
    .clear    (reg_words[REG_CTRL][CTRL_CLR_BIT]),
    .position (position),
    .errcnt   (errcnt)
  );

endmodule
